config_write_sequencer: RTL and testbench

Arbitrates configuration write requests from N_REQ requesters and drives the configuration-register load port with the address-beat/data-beat sequence it requires. Each request is a fill: one 16-bit value written to a contiguous address range (PE entries 0-63, memory config 64, network config 65+). The block sits between host/DMA config sources and the configuration register. Requesters never handle the two-beat protocol or the register's recovery cycle.

---
 rtl/config_write_sequencer.sv | 171 +++++++++++++++++
 tb/tb_config_write_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_write_sequencer.sv
// Round-robin arbiter and two-beat (address, then data) sequencer for
// configuration-register fills from N_REQ requesters.
module config_write_sequencer #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*ADDR_W-1:0]  req_len,
    input  logic [N_REQ*DATA_W-1:0]  req_value,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [DATA_W-1:0]        cfg_data,
    output logic                     cfg_valid,
    input  logic                     cfg_ready,
    output logic [15:0]              write_count
);

    localparam int unsigned GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] cur_addr, cur_addr_d;
    logic [ADDR_W-1:0] remaining, remaining_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [GNT_W-1:0]  grant_q, grant_d;
    logic [GNT_W-1:0]  last_grant, last_grant_d;
    logic              cfg_valid_d;
    logic [DATA_W-1:0] cfg_data_d;
    logic [N_REQ-1:0]  done_d;
    logic              busy_d;
    logic [CNT_W-1:0]  write_count_d;

    logic              sel_found;
    logic [GNT_W-1:0]  sel_idx;
    logic [GNT_W-1:0]  cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_len;
    logic [DATA_W-1:0] sel_value;

    // Round-robin pick: search starts one past the last granted requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = GNT_W'((32'(last_grant) + k) % N_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_value = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(sel_idx) == i) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_len   = req_len[i*ADDR_W +: ADDR_W];
                sel_value = req_value[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; req_ready is the only combinational output.
    always_comb begin
        state_d       = state;
        cur_addr_d    = cur_addr;
        remaining_d   = remaining;
        value_d       = value_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant;
        cfg_valid_d   = cfg_valid;
        cfg_data_d    = cfg_data;
        done_d        = '0;
        write_count_d = write_count;
        req_ready     = '0;

        case (state)
            S_IDLE: begin
                cfg_valid_d = 1'b0;
                cfg_data_d  = '0;
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    cur_addr_d   = sel_addr;
                    remaining_d  = sel_len;
                    value_d      = sel_value;
                    grant_d      = sel_idx;
                    last_grant_d = sel_idx;
                    cfg_valid_d  = 1'b1;
                    cfg_data_d   = DATA_W'(sel_addr);
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cfg_valid && cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    cfg_data_d  = value_q;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                write_count_d = (write_count == CNT_MAX) ? write_count
                                                         : write_count + CNT_W'(1);
                // The range is clamped at the top address instead of wrapping.
                if (remaining == '0 || cur_addr == ADDR_MAX) begin
                    done_d[grant_q] = 1'b1;
                    cfg_valid_d     = 1'b0;
                    cfg_data_d      = '0;
                    state_d         = S_IDLE;
                end else begin
                    cur_addr_d  = cur_addr + ADDR_W'(1);
                    remaining_d = remaining - ADDR_W'(1);
                    cfg_valid_d = 1'b1;
                    cfg_data_d  = DATA_W'(cur_addr + ADDR_W'(1));
                    state_d     = S_ADDR;
                end
            end
            default: begin
                cfg_valid_d = 1'b0;
                cfg_data_d  = '0;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            value_q     <= '0;
            grant_q     <= '0;
            last_grant  <= GNT_W'(N_REQ - 1);
            cfg_valid   <= 1'b0;
            cfg_data    <= '0;
            done        <= '0;
            busy        <= 1'b0;
            write_count <= '0;
        end else begin
            state       <= state_d;
            cur_addr    <= cur_addr_d;
            remaining   <= remaining_d;
            value_q     <= value_d;
            grant_q     <= grant_d;
            last_grant  <= last_grant_d;
            cfg_valid   <= cfg_valid_d;
            cfg_data    <= cfg_data_d;
            done        <= done_d;
            busy        <= busy_d;
            write_count <= write_count_d;
        end
    end

endmodule

// File: tb/tb_config_write_sequencer.sv
// Directed bench for config_write_sequencer with a 3-cycle-turnaround register model.
module tb_config_write_sequencer;

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*ADDR_W-1:0] req_len;
    logic [N_REQ*DATA_W-1:0] req_value;
    logic [N_REQ-1:0]        done;
    logic                    busy;
    logic [DATA_W-1:0]       cfg_data;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [15:0]             write_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [1:0] rec_cnt;
    logic       stall;

    logic [15:0] addr_q[$];
    logic [15:0] data_q[$];
    int          addr_cyc_q[$];
    int          grant_q[$];
    int          grant_cyc_q[$];
    int          done_q[$];
    int          done_cyc_q[$];
    bit          prev_hs;

    config_write_sequencer #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_value  (req_value),
        .done       (done),
        .busy       (busy),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register model: ready drops for one cycle two cycles after each address accept.
    assign cfg_ready = (rec_cnt != 2'd1) && !stall;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      rec_cnt <= 2'd0;
        else if (cfg_valid && cfg_ready) rec_cnt <= 2'd2;
        else if (rec_cnt != 2'd0)        rec_cnt <= rec_cnt - 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat/grant/done recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) data_q.push_back(cfg_data);
            prev_hs = cfg_valid && cfg_ready;
            if (prev_hs) begin
                addr_q.push_back(cfg_data);
                addr_cyc_q.push_back(cyc);
            end
            if (req_ready != '0) begin
                check("grant_onehot", 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < int'(N_REQ); i++)
                    if (req_ready[i]) grant_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
            if (done != '0) begin
                for (int i = 0; i < int'(N_REQ); i++)
                    if (done[i]) done_q.push_back(i);
                done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        addr_q.delete();
        data_q.delete();
        addr_cyc_q.delete();
        grant_q.delete();
        grant_cyc_q.delete();
        done_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [6:0] l,
                           input logic [15:0] v);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_len[i*ADDR_W +: ADDR_W]   = l;
        req_value[i*DATA_W +: DATA_W] = v;
        req_valid[i]                  = 1'b1;
    endtask

    // Raise a request, hold it until granted, then drop it after the accept edge.
    task automatic issue(input int i, input logic [6:0] a, input logic [6:0] l,
                         input logic [15:0] v);
        bit seen = 1'b0;
        @(negedge clk);
        set_req(i, a, l, v);
        #1;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (req_ready[i]) seen = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (!busy && !cfg_valid) ok = 1'b1;
        end
        check("idle_timeout", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_value = '0;
        stall     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_valid",  32'(cfg_valid), 32'd0);
        check("rst_data",   32'(cfg_data), 32'd0);
        check("rst_count",  32'(write_count), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        rst_n = 1'b1;
        clear_q();

        // Single write
        issue(0, 7'd5, 7'd0, 16'hA5A5);
        wait_idle();
        check("single_naddr", 32'(addr_q.size()), 32'd1);
        check("single_addr",  32'(addr_q[0]), 32'h0005);
        check("single_data",  32'(data_q[0]), 32'hA5A5);
        check("single_lat",   32'(addr_cyc_q[0] - grant_cyc_q[0]), 32'd1);
        check("single_ndone", 32'(done_q.size()), 32'd1);
        check("single_done",  32'(done_q[0]), 32'd0);
        check("single_dlat",  32'(done_cyc_q[0] - grant_cyc_q[0]), 32'd3);
        check("single_count", 32'(write_count), 32'd1);
        check("single_busy",  32'(busy), 32'd0);
        check("idle_data",    32'(cfg_data), 32'd0);
        clear_q();

        // Fill 60..65 from requester 1
        issue(1, 7'd60, 7'd5, 16'h1234);
        wait_idle();
        check("fill_naddr", 32'(addr_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("fill_addr", 32'(addr_q[k]), 32'(60 + k));
            check("fill_data", 32'(data_q[k]), 32'h1234);
        end
        check("fill_done",  32'(done_q[0]), 32'd1);
        check("fill_dur",   32'(done_cyc_q[0] - grant_cyc_q[0]), 32'd18);
        check("fill_count", 32'(write_count), 32'd7);
        clear_q();

        // Clamp at the top address
        issue(0, 7'd125, 7'd10, 16'h5A5A);
        wait_idle();
        check("clamp_naddr", 32'(addr_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("clamp_addr", 32'(addr_q[k]), 32'(125 + k));
            check("clamp_data", 32'(data_q[k]), 32'h5A5A);
        end
        check("clamp_ndone", 32'(done_q.size()), 32'd1);
        check("clamp_done",  32'(done_q[0]), 32'd0);
        check("clamp_dlast", 32'(done_cyc_q[0] - addr_cyc_q[2]), 32'd2);
        check("clamp_count", 32'(write_count), 32'd10);

        // Arbitration: both requesters continuously valid from reset
        do_reset();
        @(negedge clk);
        set_req(0, 7'd1, 7'd0, 16'h1111);
        set_req(1, 7'd2, 7'd0, 16'h2222);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (grant_q.size() >= 4) ok = 1'b1;
        end
        check("arb_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        check("arb_ngrant", 32'(grant_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("arb_grant", 32'(grant_q[k]), 32'(k % 2));
            check("arb_addr",  32'(addr_q[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("arb_data",  32'(data_q[k]), (k % 2 == 0) ? 32'h1111 : 32'h2222);
        end
        for (int k = 1; k < 4; k++)
            check("arb_spacing", 32'(grant_cyc_q[k] - grant_cyc_q[k-1]), 32'd3);
        check("arb_count", 32'(write_count), 32'd4);
        clear_q();

        // Backpressure: register holds ready low for 7 cycles in ADDR
        stall = 1'b1;
        issue(0, 7'd10, 7'd0, 16'hBEEF);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(cfg_valid), 32'd1);
            check("bp_data",  32'(cfg_data), 32'd10);
        end
        check("bp_nodata", 32'(data_q.size()), 32'd0);
        stall = 1'b0;
        wait_idle();
        check("bp_addr",  32'(addr_q[0]), 32'd10);
        check("bp_data2", 32'(data_q[0]), 32'hBEEF);
        check("bp_count", 32'(write_count), 32'd5);
        clear_q();

        // Reset during the 3rd write of a 10-write fill
        issue(0, 7'd20, 7'd9, 16'hCAFE);
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() >= 3) ok = 1'b1;
        end
        check("mid_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_ready", 32'(req_ready), 32'd0);
        check("mid_done",  32'(done), 32'd0);
        check("mid_busy",  32'(busy), 32'd0);
        check("mid_valid", 32'(cfg_valid), 32'd0);
        check("mid_data",  32'(cfg_data), 32'd0);
        check("mid_count", 32'(write_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        issue(1, 7'd65, 7'd0, 16'h0BEE);
        wait_idle();
        issue(0, 7'd64, 7'd0, 16'h0C0C);
        wait_idle();
        check("post_ngrant", 32'(grant_q.size()), 32'd2);
        check("post_first",  32'(grant_q[0]), 32'd1);
        check("post_second", 32'(grant_q[1]), 32'd0);
        check("post_naddr",  32'(addr_q.size()), 32'd2);
        check("post_addr",   32'(addr_q[0]), 32'd65);
        check("post_data",   32'(data_q[0]), 32'h0BEE);
        check("post_addr2",  32'(addr_q[1]), 32'd64);
        check("post_count",  32'(write_count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
